// File: rtl/systolic_pkg.sv
// systolic_pkg -- shared types and default constants for the systolic array
// feed scheduler.
//   sched_state_t : scheduler FSM state encoding
//   N_DEF         : default array dimension (rows = cols)
//   DW_DEF        : default operand lane width
//   K_DEF         : default inner dimension (operand beats per job)
package systolic_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } sched_state_t;

    localparam int N_DEF  = 4;
    localparam int DW_DEF = 32;
    localparam int K_DEF  = 4;

endpackage

// File: rtl/systolic_sched_skew_line.sv
// skew_line -- zero-reset shift register delaying one operand lane by DEPTH
// cycles. DEPTH = 0 degenerates to a plain wire.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset (clears every stage to zero)
//   din  : lane input  [DW-1:0]
//   dout : lane output [DW-1:0], din delayed by DEPTH cycles
module skew_line #(
    parameter int DEPTH = 1,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clk, rst};
        assign dout = din;
    end else begin : g_shift
        logic [DW-1:0] sr_q [DEPTH];
        logic [DW-1:0] sr_d [DEPTH];

        always_comb begin
            sr_d[0] = din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                sr_d[i] = sr_q[i-1];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    sr_q[i] <= '0;
                end
            end else begin
                sr_q <= sr_d;
            end
        end

        assign dout = sr_q[DEPTH-1];
    end

endmodule

// File: rtl/systolic_sched.sv
// systolic_sched -- job scheduler for an N x N output-stationary systolic
// array: clears the accumulators, streams K operand beats from the A/B
// buffers, skews them onto the west/north array edges, waits for the wave
// to drain and pulses done.
// Optional feature macro: SYSTOLIC_SCHED_PERF_EN (adds perf_jobs/perf_busy).
// Ports:
//   clk, rst           : clock (rising edge), async active-high reset
//   start              : job request, sampled only in IDLE
//   busy               : high in every state except IDLE
//   done               : one-cycle pulse, job result valid in array
//   op_rd_en/op_rd_idx : operand buffer read strobe and beat index
//   a_data/b_data      : A column / B row, valid one cycle after op_rd_en
//   west/north         : skewed operands to array rows / columns
//   arr_clr            : clear array accumulators
//   perf_jobs          : (perf build) done pulse count, wrapping
//   perf_busy          : (perf build) busy cycle count, saturating
module systolic_sched
    import systolic_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF,
    parameter int K  = K_DEF
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   op_rd_en,
    output logic [((K > 2) ? $clog2(K) : 1)-1:0]   op_rd_idx,
    input  logic [N*DW-1:0]                        a_data,
    input  logic [N*DW-1:0]                        b_data,
    output logic [N*DW-1:0]                        west,
    output logic [N*DW-1:0]                        north,
    output logic                                   arr_clr
`ifdef SYSTOLIC_SCHED_PERF_EN
    ,
    output logic [15:0]                            perf_jobs,
    output logic [31:0]                            perf_busy
`endif
);

    localparam int IW = (K > 2) ? $clog2(K) : 1;
    localparam int CW = 5;   // holds K-1 (<=15) and 2N-1 (<=15)

    sched_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rd_valid_q, rd_valid_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy      = 1'b1;
        done      = 1'b0;
        op_rd_en  = 1'b0;
        op_rd_idx = '0;
        arr_clr   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy  = 1'b0;
                cnt_d = '0;
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                arr_clr = 1'b1;
                cnt_d   = '0;
                state_d = S_FEED;
            end
            S_FEED: begin
                op_rd_en  = 1'b1;
                op_rd_idx = cnt_q[IW-1:0];
                if (cnt_q == CW'(K - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == CW'(2 * N - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operand data returns one cycle after the read strobe.
    assign rd_valid_d = op_rd_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Gate buffer data so the skew lines shift in zeros whenever no beat
    // is returning; the array edges are therefore zero outside the window.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DW-1:0] a_in, b_in;
        assign a_in = rd_valid_q ? a_data[i*DW +: DW] : '0;
        assign b_in = rd_valid_q ? b_data[i*DW +: DW] : '0;

        skew_line #(.DEPTH(i), .DW(DW)) u_west (
            .clk  (clk),
            .rst  (rst),
            .din  (a_in),
            .dout (west[i*DW +: DW])
        );

        skew_line #(.DEPTH(i), .DW(DW)) u_north (
            .clk  (clk),
            .rst  (rst),
            .din  (b_in),
            .dout (north[i*DW +: DW])
        );
    end

`ifdef SYSTOLIC_SCHED_PERF_EN
    logic [15:0] perf_jobs_q, perf_jobs_d;
    logic [31:0] perf_busy_q, perf_busy_d;

    always_comb begin
        perf_jobs_d = done ? perf_jobs_q + 16'd1 : perf_jobs_q;
        perf_busy_d = (busy && (perf_busy_q != '1)) ? perf_busy_q + 32'd1 : perf_busy_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_jobs_q <= '0;
            perf_busy_q <= '0;
        end else begin
            perf_jobs_q <= perf_jobs_d;
            perf_busy_q <= perf_busy_d;
        end
    end

    assign perf_jobs = perf_jobs_q;
    assign perf_busy = perf_busy_q;
`endif

endmodule

// File: tb/tb_systolic_sched.sv
// tb_systolic_sched -- self-checking bench for systolic_sched at default
// parameters. Control timing is checked against a per-cycle vector table;
// skewed operands are checked through a scoreboard of expected arrivals.
// Build with SYSTOLIC_SCHED_PERF_EN defined to also check the perf counters.
module tb_systolic_sched;
    import systolic_pkg::*;

    localparam int N  = N_DEF;
    localparam int DW = DW_DEF;
    localparam int K  = K_DEF;
    localparam int IW = (K > 2) ? $clog2(K) : 1;
    localparam int NV = 17;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            busy, done, op_rd_en, arr_clr;
    logic [IW-1:0]   op_rd_idx;
    logic [N*DW-1:0] a_data, b_data, west, north;
`ifdef SYSTOLIC_SCHED_PERF_EN
    logic [15:0]     perf_jobs;
    logic [31:0]     perf_busy;
`endif

    int total = 0;
    int bad   = 0;
    int cyc;

    always #5 clk = ~clk;

    systolic_sched #(.N(N), .DW(DW), .K(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .op_rd_en  (op_rd_en),
        .op_rd_idx (op_rd_idx),
        .a_data    (a_data),
        .b_data    (b_data),
        .west      (west),
        .north     (north),
        .arr_clr   (arr_clr)
`ifdef SYSTOLIC_SCHED_PERF_EN
        ,
        .perf_jobs (perf_jobs),
        .perf_busy (perf_busy)
`endif
    );

    typedef struct {
        int            due;
        int            lane;
        bit            is_west;
        logic [DW-1:0] val;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        bit            start;
        bit            busy;
        bit            clr;
        bit            rd_en;
        logic [IW-1:0] idx;
        bit            done;
    } vec_t;
    vec_t vt[NV];

    bit            rd_prev;
    logic [IW-1:0] idx_prev;

    task automatic chk(input string name, input logic [N*DW-1:0] act,
                       input logic [N*DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_val(input bit is_a, input int k, input int lane);
        logic [DW-1:0] v;
        v = DW'(k << 8) | DW'((is_a ? 32'hA0 : 32'hB0) + lane);
        return v;
    endfunction

    // One clock cycle: drive start and the buffer return data for the new
    // cycle, then check the skewed edges against the scoreboard.
    task automatic step(input bit st);
        logic [N*DW-1:0] ew, en;
        @(posedge clk);
        #1;
        cyc++;
        start = st;
        for (int i = 0; i < N; i++) begin
            if (rd_prev) begin
                a_data[i*DW +: DW] = beat_val(1'b1, int'(idx_prev), i);
                b_data[i*DW +: DW] = beat_val(1'b0, int'(idx_prev), i);
                sbq.push_back('{due: cyc + i, lane: i, is_west: 1'b1,
                                val: beat_val(1'b1, int'(idx_prev), i)});
                sbq.push_back('{due: cyc + i, lane: i, is_west: 1'b0,
                                val: beat_val(1'b0, int'(idx_prev), i)});
            end else begin
                a_data[i*DW +: DW] = DW'($urandom);
                b_data[i*DW +: DW] = DW'($urandom);
            end
        end
        #1;
        ew = '0;
        en = '0;
        for (int q = sbq.size() - 1; q >= 0; q--) begin
            if (sbq[q].due == cyc) begin
                if (sbq[q].is_west) ew[sbq[q].lane*DW +: DW] = sbq[q].val;
                else                en[sbq[q].lane*DW +: DW] = sbq[q].val;
                sbq.delete(q);
            end
        end
        chk("west", west, ew);
        chk("north", north, en);
        rd_prev  = op_rd_en;
        idx_prev = op_rd_idx;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, N*DW'(busy), '0);
        chk({tag, "_done"}, N*DW'(done), '0);
        chk({tag, "_rd_en"}, N*DW'(op_rd_en), '0);
        chk({tag, "_idx"}, N*DW'(op_rd_idx), '0);
        chk({tag, "_clr"}, N*DW'(arr_clr), '0);
        chk({tag, "_west"}, west, '0);
        chk({tag, "_north"}, north, '0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        start    = 1'b0;
        a_data   = '0;
        b_data   = '0;
        rd_prev  = 1'b0;
        idx_prev = '0;
        sbq.delete();
        @(posedge clk);
        #1;
        chk_quiet("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Run one job from the vector table; optionally pulse start again in
    // FEED (cycle 3) and DRAIN (cycle 9), which must be ignored.
    task automatic run_table(input bit extra_starts);
        int ndone = 0;
        cyc = -1;
        for (int c = 0; c < NV; c++) begin
            step(vt[c].start || (extra_starts && (c == 3 || c == 9)));
            chk("busy", N*DW'(busy), N*DW'(vt[c].busy));
            chk("arr_clr", N*DW'(arr_clr), N*DW'(vt[c].clr));
            chk("op_rd_en", N*DW'(op_rd_en), N*DW'(vt[c].rd_en));
            chk("op_rd_idx", N*DW'(op_rd_idx), N*DW'(vt[c].idx));
            chk("done", N*DW'(done), N*DW'(vt[c].done));
            if (c == 6) chk("west3_a3", N*DW'(west[3*DW +: DW]), N*DW'(32'hA3));
            if (done) ndone++;
        end
        chk("done_count", N*DW'(ndone), N*DW'(1));
    endtask

    initial begin
        for (int c = 0; c < NV; c++) begin
            vt[c].start = (c == 0);
            vt[c].busy  = (c >= 1 && c <= 14);
            vt[c].clr   = (c == 1);
            vt[c].rd_en = (c >= 2 && c <= 5);
            vt[c].idx   = (c >= 2 && c <= 5) ? IW'(c - 2) : '0;
            vt[c].done  = (c == 14);
        end

        do_reset();
`ifdef SYSTOLIC_SCHED_PERF_EN
        chk("perf_jobs_rst", N*DW'(perf_jobs), '0);
        chk("perf_busy_rst", N*DW'(perf_busy), '0);
`endif

        // Basic job timing and skew.
        run_table(1'b0);

        // Start pulses during FEED and DRAIN are ignored.
        run_table(1'b1);

        // Start held high: back-to-back jobs, done period 15.
        begin
            int ndone = 0;
            cyc = -1;
            for (int c = 0; c < 50; c++) begin
                step(1'b1);
                chk("held_done", N*DW'(done), N*DW'((c % 15) == 14));
                chk("held_clr", N*DW'(arr_clr), N*DW'((c % 15) == 1));
                chk("held_busy", N*DW'(busy), N*DW'((c % 15) != 0));
                if (done) ndone++;
            end
            for (int c = 50; c < 61; c++) begin
                step(1'b0);
                if (done) ndone++;
            end
            chk("held_done_count", N*DW'(ndone), N*DW'(4));
            chk("held_idle", N*DW'(busy), '0);
        end

        // Reset in DRAIN: outputs clear asynchronously, no done, then a full job.
        begin
            cyc = -1;
            for (int c = 0; c < 9; c++) step(c == 0);
            chk("pre_abort_busy", N*DW'(busy), N*DW'(1));
            #1;
            rst = 1'b1;
            #1;
            chk_quiet("async_rst");
            sbq.delete();
            rd_prev  = 1'b0;
            idx_prev = '0;
            for (int c = 0; c < 8; c++) begin
                @(posedge clk);
                #1;
                chk("abort_no_done", N*DW'(done), '0);
            end
            rst = 1'b0;
            run_table(1'b0);
        end

`ifdef SYSTOLIC_SCHED_PERF_EN
        do_reset();
        for (int j = 0; j < 3; j++) run_table(1'b0);
        chk("perf_jobs", N*DW'(perf_jobs), N*DW'(3));
        chk("perf_busy", N*DW'(perf_busy), N*DW'(42));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
